usb_ep_fifo: RTL and testbench



---
 rtl/usb_ep_fifo_pkg.sv | 13 +
 rtl/usb_ep_fifo_ram.sv | 26 ++
 rtl/usb_ep_fifo.sv | 112 +++++++++++
 tb/tb_usb_ep_fifo.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/usb_ep_fifo_pkg.sv
// Shared definitions for the endpoint FIFO: pointer sizing and
// the fixed priorities between conflicting commands.
package usb_ep_fifo_pkg;

  localparam bit ABORT_OVER_COMMIT = 1'b1;
  localparam bit ACK_OVER_REWIND   = 1'b1;

  // One extra bit distinguishes full from empty.
  function automatic int ptr_w(input int log2_depth);
    return log2_depth + 1;
  endfunction

endpackage

// File: rtl/usb_ep_fifo_ram.sv
// Simple dual-port RAM with a registered read port.
// A read strobe gates the output register so held data persists.
module usb_ep_fifo_ram #(
  parameter int WIDTH = 8,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [2**AW];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/usb_ep_fifo.sv
// Endpoint FIFO with speculative write (commit/abort) and
// speculative read (ack/rewind) pointer pairs.
module usb_ep_fifo
  import usb_ep_fifo_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LOG2_DEPTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  wr_ena,
  input  logic                  wr_commit,
  input  logic                  wr_abort,
  output logic                  wr_full,
  output logic [LOG2_DEPTH:0]   wr_space,
  output logic                  wr_ovf,
  output logic [WIDTH-1:0]      rd_data_1,
  input  logic                  rd_ena,
  input  logic                  rd_ack,
  input  logic                  rd_rewind,
  output logic                  rd_empty,
  output logic [LOG2_DEPTH:0]   rd_avail
);

  localparam int PW = ptr_w(LOG2_DEPTH);
  localparam logic [PW-1:0] DEPTH_P = {1'b1, {LOG2_DEPTH{1'b0}}};

  logic [PW-1:0] wp_spec_q, wp_spec_d;
  logic [PW-1:0] wp_cmt_q, wp_cmt_d;
  logic [PW-1:0] rp_spec_q, rp_spec_d;
  logic [PW-1:0] rp_ack_q, rp_ack_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;
  logic          empty_q, empty_d;
  logic [PW-1:0] space_q, space_d;
  logic [PW-1:0] avail_q, avail_d;
  logic [PW-1:0] used, avail;
  logic          wr_acc, rd_acc, cmt, rew;

  always_comb begin
    wr_acc = wr_ena && !full_q && !wr_abort;
    cmt    = wr_commit && !(ABORT_OVER_COMMIT && wr_abort);
    rd_acc = rd_ena && !empty_q && !rd_rewind;
    rew    = rd_rewind && !(ACK_OVER_REWIND && rd_ack);

    wp_spec_d = wp_spec_q + PW'(wr_acc);
    wp_cmt_d  = wp_cmt_q;
    if (wr_abort) wp_spec_d = wp_cmt_q;
    else if (cmt) wp_cmt_d = wp_spec_d;

    ovf_d = ovf_q;
    if (wr_ena && full_q) ovf_d = 1'b1;
    if (wr_abort || cmt) ovf_d = 1'b0;

    rp_spec_d = rp_spec_q + PW'(rd_acc);
    rp_ack_d  = rd_ack ? rp_spec_d : rp_ack_q;
    if (rew) rp_spec_d = rp_ack_q;

    // Levels are derived from next-state pointers, then registered.
    used    = wp_spec_d - rp_ack_d;
    avail   = wp_cmt_d - rp_spec_d;
    full_d  = (used == DEPTH_P);
    space_d = DEPTH_P - used;
    empty_d = (avail == '0);
    avail_d = avail;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_spec_q <= '0;
      wp_cmt_q  <= '0;
      rp_spec_q <= '0;
      rp_ack_q  <= '0;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
      empty_q   <= 1'b1;
      space_q   <= DEPTH_P;
      avail_q   <= '0;
    end else begin
      wp_spec_q <= wp_spec_d;
      wp_cmt_q  <= wp_cmt_d;
      rp_spec_q <= rp_spec_d;
      rp_ack_q  <= rp_ack_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
      empty_q   <= empty_d;
      space_q   <= space_d;
      avail_q   <= avail_d;
    end
  end

  usb_ep_fifo_ram #(
    .WIDTH (WIDTH),
    .AW    (LOG2_DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc && !rst),
    .waddr (wp_spec_q[LOG2_DEPTH-1:0]),
    .wdata (wr_data),
    .re    (rd_acc && !rst),
    .raddr (rp_spec_q[LOG2_DEPTH-1:0]),
    .rdata (rd_data_1)
  );

  assign wr_full  = full_q;
  assign wr_space = space_q;
  assign wr_ovf   = ovf_q;
  assign rd_empty = empty_q;
  assign rd_avail = avail_q;

endmodule

// File: tb/tb_usb_ep_fifo.sv
// Directed bench for usb_ep_fifo at WIDTH=8, DEPTH=16.
module tb_usb_ep_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wr_data;
  logic       wr_ena, wr_commit, wr_abort;
  logic       wr_full, wr_ovf;
  logic [4:0] wr_space;
  logic [7:0] rd_data_1;
  logic       rd_ena, rd_ack, rd_rewind;
  logic       rd_empty;
  logic [4:0] rd_avail;

  int n_chk = 0;
  int n_bad = 0;
  int d;
  int last_rd;

  always #5 clk = ~clk;

  usb_ep_fifo #(.WIDTH(8), .LOG2_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_data   (wr_data),
    .wr_ena    (wr_ena),
    .wr_commit (wr_commit),
    .wr_abort  (wr_abort),
    .wr_full   (wr_full),
    .wr_space  (wr_space),
    .wr_ovf    (wr_ovf),
    .rd_data_1 (rd_data_1),
    .rd_ena    (rd_ena),
    .rd_ack    (rd_ack),
    .rd_rewind (rd_rewind),
    .rd_empty  (rd_empty),
    .rd_avail  (rd_avail)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // One clock with the given strobes; outputs settle #1 after the edge.
  task automatic cyc(input logic we, input int wd, input logic cm,
                     input logic ab, input logic re, input logic ak,
                     input logic rw);
    wr_ena = we; wr_data = 8'(wd); wr_commit = cm; wr_abort = ab;
    rd_ena = re; rd_ack = ak; rd_rewind = rw;
    @(posedge clk); #1;
    wr_ena = 0; wr_commit = 0; wr_abort = 0;
    rd_ena = 0; rd_ack = 0; rd_rewind = 0;
  endtask

  task automatic wr(input int wd);
    cyc(1, wd, 0, 0, 0, 0, 0);
  endtask

  task automatic rd(input string tag, input int exp, input logic ak);
    cyc(0, 0, 0, 0, 1, ak, 0);
    chk(tag, rd_data_1, exp);
    last_rd = exp;
  endtask

  initial begin
    rst = 1; wr_data = 0; wr_ena = 0; wr_commit = 0; wr_abort = 0;
    rd_ena = 0; rd_ack = 0; rd_rewind = 0;
    @(posedge clk); #1;
    rst = 0;
    chk("rst_full", wr_full, 0);
    chk("rst_space", wr_space, 16);
    chk("rst_ovf", wr_ovf, 0);
    chk("rst_empty", rd_empty, 1);
    chk("rst_avail", rd_avail, 0);

    for (int i = 0; i < 5; i++) wr(8'h10 + i);
    chk("t1_empty_spec", rd_empty, 1);
    chk("t1_space", wr_space, 11);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("t1_avail", rd_avail, 5);
    chk("t1_empty", rd_empty, 0);
    for (int i = 0; i < 5; i++) rd("t1_rd", 8'h10 + i, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("t1_space_ack", wr_space, 16);
    chk("t1_empty_end", rd_empty, 1);

    for (int i = 0; i < 3; i++) wr(8'hA0 + i);
    cyc(0, 0, 1, 0, 0, 0, 0);
    wr(8'hB0); wr(8'hB1);
    cyc(1, 8'hB2, 0, 1, 0, 0, 0);
    chk("t2_space", wr_space, 13);
    chk("t2_avail", rd_avail, 3);
    cyc(1, 8'hC0, 1, 0, 0, 0, 0);
    rd("t2_rd0", 8'hA0, 0);
    rd("t2_rd1", 8'hA1, 0);
    rd("t2_rd2", 8'hA2, 0);
    rd("t2_rd3", 8'hC0, 1);
    chk("t2_empty", rd_empty, 1);

    for (int i = 1; i <= 4; i++) wr(i);
    cyc(0, 0, 1, 0, 0, 0, 0);
    rd("t3_rd1", 1, 0);
    rd("t3_rd2", 2, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("t3_rew_avail", rd_avail, 4);
    rd("t3_rr1", 1, 0);
    rd("t3_rr2", 2, 0);
    rd("t3_rr3", 3, 1);
    chk("t3_space", wr_space, 15);
    chk("t3_avail", rd_avail, 1);
    rd("t3_rd4", 4, 1);
    chk("t3_space_end", wr_space, 16);

    for (int i = 0; i < 15; i++) wr(8'h40 + i);
    cyc(0, 0, 1, 0, 0, 0, 0);
    wr(8'h4F);
    chk("t4_full", wr_full, 1);
    chk("t4_space0", wr_space, 0);
    wr(8'hEE);
    chk("t4_ovf", wr_ovf, 1);
    chk("t4_full2", wr_full, 1);
    rd("t4_rd", 8'h40, 0);
    chk("t4_full_noack", wr_full, 1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("t4_full_ack", wr_full, 0);
    chk("t4_space1", wr_space, 1);
    chk("t4_ovf_hold", wr_ovf, 1);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("t4_ovf_clr", wr_ovf, 0);
    chk("t4_avail", rd_avail, 15);
    for (int i = 1; i < 16; i++) rd("t4_drain", 8'h40 + i, 1);
    chk("t4_empty", rd_empty, 1);

    d = 0;
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 7; i++) begin
        wr(d + i);
        chk("t5_wspace", wr_space, 15 - i);
        chk("t5_wavail", rd_avail, 0);
      end
      cyc(0, 0, 1, 0, 0, 0, 0);
      chk("t5_cavail", rd_avail, 7);
      for (int i = 0; i < 7; i++) begin
        rd("t5_rd", (d + i) & 8'hFF, 0);
        chk("t5_ravail", rd_avail, 6 - i);
        chk("t5_rspace", wr_space, 9);
      end
      cyc(0, 0, 0, 0, 0, 1, 0);
      chk("t5_aspace", wr_space, 16);
      d += 7;
    end

    for (int i = 0; i < 5; i++) wr(8'h70 + i);
    cyc(0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) wr(8'h80 + i);
    chk("t6_pre_avail", rd_avail, 5);
    rst = 1;
    cyc(1, 8'h99, 0, 0, 1, 0, 0);
    rst = 0;
    chk("t6_empty", rd_empty, 1);
    chk("t6_space", wr_space, 16);
    chk("t6_ovf", wr_ovf, 0);
    chk("t6_avail", rd_avail, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("t6_rd_ign_data", rd_data_1, last_rd);
    chk("t6_rd_ign_avail", rd_avail, 0);
    chk("t6_rd_ign_space", wr_space, 16);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
